// File: rtl/mac_act_bank.sv
// Two-stage signed multiply-accumulate with saturation, followed by requantisation
// into an N-entry activation bank written by a one-hot enable from the controller.
module mac_act_bank #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACCW  = 24,
    parameter int unsigned N     = 64,
    parameter int unsigned SHIFT = 6,
    localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mac_clr,
    input  logic                   in_valid,
    input  logic signed [DW-1:0]   act_in,
    input  logic signed [DW-1:0]   w_in,
    input  logic                   relu_en,
    input  logic        [N-1:0]    we,
    input  logic        [AW-1:0]   rd_addr,
    output logic signed [DW-1:0]   rd_data,
    output logic signed [ACCW-1:0] acc_out,
    output logic                   ovf,
    output logic                   we_err
);

    localparam int unsigned PW = 2 * DW;

    localparam logic signed [ACCW-1:0] AccMax = {1'b0, {(ACCW - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] AccMin = {1'b1, {(ACCW - 1){1'b0}}};
    localparam logic signed [ACCW-1:0] QMax   = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] QMin   = -QMax - ACCW'(1);

    // ------------------------------------------------------------------
    // Stage 1: product register
    // ------------------------------------------------------------------
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 p_vld_q, p_vld_d;

    always_comb begin
        prod_d  = PW'(act_in) * PW'(w_in);
        p_vld_d = in_valid;
        if (mac_clr) begin
            prod_d  = '0;
            p_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            p_vld_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            p_vld_q <= p_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturating accumulator
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW:0]   sum;
    logic                   sat;
    logic                   ovf_q, ovf_d;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign sum = (ACCW + 1)'(acc_q) + (ACCW + 1)'(prod_q);
    assign sat = p_vld_q && (sum[ACCW] != sum[ACCW-1]);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (mac_clr) begin
            acc_d = '0;
        end else if (p_vld_q) begin
            if (sat) begin
                acc_d = sum[ACCW] ? AccMin : AccMax;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACCW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

    // ------------------------------------------------------------------
    // Requantisation of the current accumulator
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] shifted;
    logic signed [ACCW-1:0] q_wide;
    logic signed [DW-1:0]   q;

    always_comb begin
        shifted = acc_q >>> SHIFT;
        q_wide  = shifted;
        if (relu_en && shifted < 0) begin
            q_wide = '0;
        end else if (shifted > QMax) begin
            q_wide = QMax;
        end else if (shifted < QMin) begin
            q_wide = QMin;
        end
        q = q_wide[DW-1:0];
    end

    // ------------------------------------------------------------------
    // Activation bank
    // ------------------------------------------------------------------
    logic signed [DW-1:0] bank_q [N];
    logic                 we_any;
    logic                 we_multi;
    logic                 we_one;
    logic                 we_err_q, we_err_d;

    // we & (we - 1) clears the lowest set bit; anything left means two or more.
    assign we_any   = |we;
    assign we_multi = |(we & (we - N'(1)));
    assign we_one   = we_any && !we_multi;

    always_comb begin
        we_err_d = we_err_q | we_multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_err_q <= 1'b0;
        end else begin
            we_err_q <= we_err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (rst) begin
                bank_q[i] <= '0;
            end else if (we_one && we[i]) begin
                bank_q[i] <= q;
            end
        end
    end

    assign we_err  = we_err_q;
    assign rd_data = (32'(rd_addr) < N) ? bank_q[rd_addr] : '0;

endmodule

// File: tb/tb_mac_act_bank.sv
// Directed-vector bench for mac_act_bank with hand-computed expectations.
module tb_mac_act_bank;

    localparam int DW   = 8;
    localparam int ACCW = 24;
    localparam int N    = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   mac_clr;
    logic                   in_valid;
    logic signed [DW-1:0]   act_in;
    logic signed [DW-1:0]   w_in;
    logic                   relu_en;
    logic        [N-1:0]    we;
    logic        [5:0]      rd_addr;
    logic signed [DW-1:0]   rd_data;
    logic signed [ACCW-1:0] acc_out;
    logic                   ovf;
    logic                   we_err;

    int n_vec = 0;
    int n_bad = 0;

    mac_act_bank #(
        .DW   (DW),
        .ACCW (ACCW),
        .N    (N),
        .SHIFT(6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mac_clr (mac_clr),
        .in_valid(in_valid),
        .act_in  (act_in),
        .w_in    (w_in),
        .relu_en (relu_en),
        .we      (we),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .acc_out (acc_out),
        .ovf     (ovf),
        .we_err  (we_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int a, input int w);
        in_valid = 1'b1;
        act_in   = DW'(a);
        w_in     = DW'(w);
        step();
        in_valid = 1'b0;
    endtask

    task automatic clear_acc();
        mac_clr = 1'b1;
        step();
        mac_clr = 1'b0;
    endtask

    task automatic write_entry(input int k, input logic relu);
        relu_en = relu;
        we      = N'(1) << k;
        step();
        we      = '0;
    endtask

    task automatic read_entry(input string tag, input int k, input int exp);
        rd_addr = 6'(k);
        #1;
        check_val(tag, int'(rd_data), exp);
    endtask

    initial begin
        int nonzero;

        rst      = 1'b1;
        mac_clr  = 1'b0;
        in_valid = 1'b0;
        act_in   = '0;
        w_in     = '0;
        relu_en  = 1'b1;
        we       = '0;
        rd_addr  = '0;
        step();
        step();
        rst = 1'b0;

        check_val("reset_acc", int'(acc_out), 0);
        check_val("reset_ovf", int'(ovf), 0);
        check_val("reset_we_err", int'(we_err), 0);

        // Basic accumulation and one-cycle latency
        pair(3, 4);
        check_val("latency_acc0", int'(acc_out), 0);
        pair(5, -2);
        check_val("latency_acc12", int'(acc_out), 12);
        pair(10, 10);
        check_val("acc_partial", int'(acc_out), 2);
        step();
        check_val("acc_102", int'(acc_out), 102);
        rd_addr = 6'd5;
        relu_en = 1'b1;
        we      = N'(1) << 5;
        #1;
        check_val("no_bypass", int'(rd_data), 0);
        step();
        we = '0;
        check_val("bank5", int'(rd_data), 1);
        check_val("acc_kept_by_we", int'(acc_out), 102);
        step();
        check_val("we0_keeps_bank5", int'(rd_data), 1);

        // Negative accumulator, ReLU vs signed clamp
        clear_acc();
        pair(-100, 100);
        step();
        check_val("acc_neg", int'(acc_out), -10000);
        write_entry(0, 1'b1);
        read_entry("bank0_relu", 0, 0);
        write_entry(0, 1'b0);
        read_entry("bank0_clamp", 0, -128);
        check_val("acc_neg_kept", int'(acc_out), -10000);

        // Write with mac_clr in the same cycle: pre-clear value stored
        clear_acc();
        pair(20, 20);
        step();
        mac_clr = 1'b1;
        write_entry(3, 1'b1);
        mac_clr = 1'b0;
        read_entry("bank3_preclear", 3, 6);
        check_val("acc_cleared_with_we", int'(acc_out), 0);

        // Saturation
        clear_acc();
        for (int i = 0; i < 500; i++) pair(127, 127);
        check_val("acc_pre_sat", int'(acc_out), 8048371);
        check_val("ovf_pre_sat", int'(ovf), 0);
        for (int i = 0; i < 100; i++) pair(127, 127);
        step();
        check_val("acc_sat", int'(acc_out), 8388607);
        check_val("ovf_set", int'(ovf), 1);
        write_entry(2, 1'b1);
        read_entry("bank2_sat", 2, 127);

        // Negative saturation
        clear_acc();
        check_val("ovf_sticky_clr", int'(ovf), 1);
        for (int i = 0; i < 600; i++) pair(-128, 127);
        step();
        check_val("acc_sat_neg", int'(acc_out), -8388608);
        write_entry(4, 1'b0);
        read_entry("bank4_sat_neg", 4, -128);

        // mac_clr discards the in-flight product and the same-cycle pair
        clear_acc();
        pair(9, 9);
        mac_clr  = 1'b1;
        in_valid = 1'b1;
        act_in   = 8'sd7;
        w_in     = 8'sd7;
        step();
        mac_clr  = 1'b0;
        in_valid = 1'b0;
        step();
        check_val("clr_discard", int'(acc_out), 0);

        // Multi-bit write enable
        pair(50, 50);
        step();
        we = N'(3);
        step();
        we = '0;
        check_val("we_err_set", int'(we_err), 1);
        read_entry("multi_bank0", 0, -128);
        read_entry("multi_bank1", 1, 0);
        step();
        check_val("we_err_sticky", int'(we_err), 1);

        // Reset clears everything
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_we_err", int'(we_err), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_acc", int'(acc_out), 0);
        nonzero = 0;
        for (int k = 0; k < N; k++) begin
            rd_addr = 6'(k);
            #1;
            if (rd_data != 0) nonzero++;
        end
        check_val("rst_bank_nonzero", nonzero, 0);

        // Reset mid-accumulation drops the in-flight product
        pair(10, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_val("rst_inflight", int'(acc_out), 0);
        pair(2, 3);
        step();
        check_val("resume_after_rst", int'(acc_out), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
